// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lab_pkg
//  Purpose  : Shared types and constants for the button event UART block.
//             Holds the TX state encoding, the parity mode constants and the
//             event-code layout.
//  Revision : 1.0  initial release
// ============================================================================
package lab_pkg;

  // UART transmitter states
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Parity modes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Event direction bit values
  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Event code layout: {dir, 3'b000, idx[3:0]}
  typedef struct packed {
    logic       dir;
    logic [2:0] rsvd;
    logic [3:0] idx;
  } evt_code_t;

  function automatic logic [7:0] evt_code(input logic dir, input logic [3:0] idx);
    evt_code_t c;
    c.dir  = dir;
    c.rsvd = 3'b000;
    c.idx  = idx;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_core
//  Purpose  : 8-bit UART transmitter. Start bit, 8 data bits LSB first,
//             optional even/odd parity, 1 or 2 stop bits. A byte is accepted
//             when start is high while ready is high.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_core
  import lab_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);

  // The stop phase is the longest single state, so it sizes the baud counter.
  localparam int                STOP_CYC  = STOP_BITS * CLKS_PER_BIT;
  localparam int                BAUD_W    = $clog2(STOP_CYC);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CYC - 1);
  localparam logic              PAR_INV   = (PARITY == PARITY_ODD);
  localparam logic              PAR_EN    = (PARITY != PARITY_NONE);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              par_q;
  logic              tx_q;
  logic              ready_q;

  // Frame FSM: every state holds its line level for whole bit periods; tx and
  // ready are registered so the serial line never glitches.
  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (start) begin
            shift_q <= data;
            par_q   <= (^data) ^ PAR_INV;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= TX_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_q == BIT_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              if (PAR_EN) begin
                tx_q    <= par_q;
                state_q <= TX_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= TX_STOP;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_PARITY: begin
          if (baud_q == BIT_LAST) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= TX_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_q == STOP_LAST) begin
            baud_q  <= '0;
            ready_q <= 1'b1;
            state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;

endmodule
`default_nettype wire

// File: rtl/btn_event_uart.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_uart
//  Purpose  : Synchronises and debounces push-buttons, turns debounced
//             press/release changes into 8-bit event codes, queues them in a
//             small FIFO and reports them over a UART line.
//  Revision : 1.0  initial release
// ============================================================================
module btn_event_uart
  import lab_pkg::*;
#(
  parameter int N_BTN        = 5,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk_25m,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic             rs232_tx,
  output logic [7:0]       led,
  output logic             tx_busy,
  output logic             ovf
);

  localparam int               CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam int               AW      = $clog2(FIFO_DEPTH);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] deb_q, deb_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] flip_w;
  logic [N_BTN-1:0] grant_w;
  logic [3:0]       idx_w;
  logic             dir_w;
  logic             push_w;
  logic [7:0]       code_w;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             full_w, empty_w, pop_w, wr_w;
  logic [7:0]       tx_data_q;
  logic             start_q;
  logic             tx_ready_w;
  logic [7:0]       led_q;
  logic             ovf_q;

  // Per-button debounce counter: runs only while the synchronised input
  // disagrees with the debounced state, flips it after DEBOUNCE_CYC cycles.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [CNT_W-1:0] cnt_q;

    // Stability counter for this button
    always_ff @(posedge clk_25m) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (sync2_q[i] == deb_q[i] || cnt_q == CNT_MAX) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign flip_w[i] = (sync2_q[i] != deb_q[i]) && (cnt_q == CNT_MAX);
  end

  // Lowest-index pending button wins; its direction is read at service time
  // so a double flip before service collapses into the newest direction.
  always_comb begin
    grant_w = '0;
    idx_w   = '0;
    dir_w   = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_w    = '0;
        grant_w[i] = 1'b1;
        idx_w      = 4'(i);
        dir_w      = deb_q[i];
      end
    end
    push_w = |pending_q;
    code_w = evt_code(dir_w ? EVT_PRESS : EVT_RELEASE, idx_w);
    // A new flip on the serviced bit in the same cycle re-arms it.
    deb_d     = deb_q ^ flip_w;
    pending_d = (pending_q & ~grant_w) | flip_w;
  end

  // Input synchronisers, debounced state and pending event flags
  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      pending_q <= '0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      pending_q <= pending_d;
    end
  end

  // FIFO flags; a pop frees the slot the same cycle, so push-on-full with a
  // concurrent pop is still accepted. start_q blocks a second pop while the
  // transmitter has not yet dropped ready.
  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_w   = tx_ready_w && !start_q && !empty_w;
  assign wr_w    = push_w && (!full_w || pop_w);

  // Event storage (no reset needed; validity is tracked by the pointers)
  always_ff @(posedge clk_25m) begin
    if (wr_w) begin
      mem_q[wptr_q[AW-1:0]] <= code_w;
    end
  end

  // FIFO pointers, head register, LED mirror and sticky overflow
  always_ff @(posedge clk_25m) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      tx_data_q <= '0;
      start_q   <= 1'b0;
      led_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      start_q <= pop_w;
      if (pop_w) begin
        tx_data_q <= mem_q[rptr_q[AW-1:0]];
        rptr_q    <= rptr_q + 1'b1;
      end
      if (wr_w) begin
        wptr_q <= wptr_q + 1'b1;
        led_q  <= code_w;
      end
      if (push_w && !wr_w) begin
        ovf_q <= 1'b1;
      end
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY       (PARITY),
    .STOP_BITS    (STOP_BITS)
  ) u_tx (
    .clk_25m (clk_25m),
    .rst_n   (rst_n),
    .data    (tx_data_q),
    .start   (start_q),
    .ready   (tx_ready_w),
    .tx      (rs232_tx)
  );

  assign led     = led_q;
  assign ovf     = ovf_q;
  assign tx_busy = ~tx_ready_w;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_uart.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_btn_event_uart
//  Purpose  : Directed self-checking bench for btn_event_uart.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_event_uart;

  localparam int CLK_NS = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  btn0;
  logic [3:0]  btn1, btn2;
  logic [15:0] btn3;
  logic        tx0, tx1, tx2, tx3;
  logic        busy0, busy1, busy2, busy3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic [7:0]  led0, led1, led2, led3;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic samp [4096];

  always #(CLK_NS/2) clk = ~clk;

  btn_event_uart #(.N_BTN(8), .DEBOUNCE_CYC(4), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.clk_25m(clk), .rst_n(rst_n), .btn(btn0), .rs232_tx(tx0), .led(led0), .tx_busy(busy0), .ovf(ovf0));
  btn_event_uart #(.N_BTN(4), .DEBOUNCE_CYC(4), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut1 (.clk_25m(clk), .rst_n(rst_n), .btn(btn1), .rs232_tx(tx1), .led(led1), .tx_busy(busy1), .ovf(ovf1));
  btn_event_uart #(.N_BTN(4), .DEBOUNCE_CYC(4), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut2 (.clk_25m(clk), .rst_n(rst_n), .btn(btn2), .rs232_tx(tx2), .led(led2), .tx_busy(busy2), .ovf(ovf2));
  btn_event_uart #(.N_BTN(16), .DEBOUNCE_CYC(4), .CLKS_PER_BIT(217), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut3 (.clk_25m(clk), .rst_n(rst_n), .btn(btn3), .rs232_tx(tx3), .led(led3), .tx_busy(busy3), .ovf(ovf3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic txw(input int w);
    case (w)
      0:       return tx0;
      1:       return tx1;
      2:       return tx2;
      default: return tx3;
    endcase
  endfunction

  function automatic logic busyw(input int w);
    case (w)
      0:       return busy0;
      1:       return busy1;
      2:       return busy2;
      default: return busy3;
    endcase
  endfunction

  // Wait for the start bit; n is the number of cycles waited.
  task automatic wait_start(input int w, input int budget, input string tag, output int n);
    n = 0;
    while (txw(w) !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_start_seen"}, {31'b0, txw(w)}, 32'd0);
  endtask

  task automatic wait_idle(input int w, input int budget, input string tag);
    int n = 0;
    while (busyw(w) !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle_seen"}, {31'b0, busyw(w)}, 32'd0);
  endtask

  // Called on the first cycle of a start bit. Samples the line every cycle
  // until tx_busy drops; len = cycles from start bit to idle, bits[k] = centre
  // of bit k, first_one = index of the first high sample.
  task automatic rec_frame(input int w, input int cpb, output int len,
                           output logic [11:0] bits, output int first_one);
    int n = 0;
    first_one = -1;
    do begin
      samp[n] = txw(w);
      if (first_one < 0 && samp[n] === 1'b1) first_one = n;
      n++;
      tick(1);
    end while (busyw(w) === 1'b1 && n < 4096);
    len  = n;
    bits = '0;
    for (int k = 0; k < 12; k++) begin
      if (k * cpb + cpb / 2 < n) bits[k] = samp[k * cpb + cpb / 2];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len, fo, nw;
    logic [11:0] bits;
    logic [7:0]  q5 [4];
    q5 = '{8'h81, 8'h02, 8'h83, 8'h84};

    rst_n = 1'b0;
    btn0  = '0;
    btn1  = '0;
    btn2  = '0;
    btn3  = '0;
    tick(3);
    chk("rst_tx",   {31'b0, tx0},   32'd1);
    chk("rst_led",  {24'b0, led0},  32'd0);
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_ovf",  {31'b0, ovf0},  32'd0);
    rst_n = 1'b1;
    tick(2);

    // 3-cycle glitch must be filtered out
    btn0[1] = 1'b1;
    tick(3);
    btn0[1] = 1'b0;
    tick(20);
    chk("bounce_led",  {24'b0, led0},  32'd0);
    chk("bounce_busy", {31'b0, busy0}, 32'd0);

    // Single press: led at edge 7, start bit at edge 9, frame 0,0,1,0,0,0,0,0,1,1
    btn0[2] = 1'b1;
    tick(6);
    chk("t2_led_e6", {24'b0, led0}, 32'h00);
    tick(1);
    chk("t2_led_e7", {24'b0, led0}, 32'h82);
    tick(1);
    chk("t2_tx_e8", {31'b0, tx0}, 32'd1);
    tick(1);
    chk("t2_tx_e9",   {31'b0, tx0},   32'd0);
    chk("t2_busy_e9", {31'b0, busy0}, 32'd1);
    rec_frame(0, 4, len, bits, fo);
    chk("t2_frame", {22'b0, bits[9:0]}, 32'h304);
    chk("t2_len",   len,                32'd40);

    // Two simultaneous presses: lowest index first, back-to-back frames
    btn0[0] = 1'b1;
    btn0[3] = 1'b1;
    tick(7);
    chk("t3_led_80", {24'b0, led0}, 32'h80);
    tick(1);
    chk("t3_led_83", {24'b0, led0}, 32'h83);
    tick(1);
    rec_frame(0, 4, len, bits, fo);
    chk("t3_data_80", {24'b0, bits[8:1]}, 32'h80);
    wait_start(0, 20, "t3b", nw);
    chk("t3_gap", nw, 32'd2);
    rec_frame(0, 4, len, bits, fo);
    chk("t3_data_83", {24'b0, bits[8:1]}, 32'h83);
    btn0[3] = 1'b0;
    tick(7);
    chk("t3_led_03", {24'b0, led0}, 32'h03);
    wait_start(0, 20, "t3c", nw);
    rec_frame(0, 4, len, bits, fo);
    chk("t3_data_03", {24'b0, bits[8:1]}, 32'h03);

    // Even parity with 2 stop bits, odd parity with 1 stop bit
    btn1[3] = 1'b1;
    wait_start(1, 20, "t4e", nw);
    chk("t4e_lat", nw, 32'd9);
    rec_frame(1, 4, len, bits, fo);
    chk("t4e_frame", {21'b0, bits[10:0]}, 32'h706);
    chk("t4e_len",   len,                 32'd48);
    btn2[3] = 1'b1;
    wait_start(2, 20, "t4o", nw);
    rec_frame(2, 4, len, bits, fo);
    chk("t4o_frame", {21'b0, bits[10:0]}, 32'h506);
    chk("t4o_len",   len,                 32'd44);

    // Six simultaneous events: 00 popped, 81/02/83/84 queued, 85 dropped
    btn0 = 8'h3A;
    tick(11);
    chk("t5_led_e11", {24'b0, led0}, 32'h84);
    chk("t5_ovf_e11", {31'b0, ovf0}, 32'd0);
    tick(1);
    chk("t5_ovf_e12", {31'b0, ovf0}, 32'd1);
    chk("t5_led_e12", {24'b0, led0}, 32'h84);
    wait_idle(0, 100, "t5a");
    for (int i = 0; i < 4; i++) begin
      wait_start(0, 20, "t5q", nw);
      rec_frame(0, 4, len, bits, fo);
      chk("t5_queued", {24'b0, bits[8:1]}, {24'b0, q5[i]});
    end
    tick(20);
    chk("t5_no_sixth", {31'b0, busy0}, 32'd0);
    chk("t5_ovf_hold", {31'b0, ovf0},  32'd1);
    chk("t5_led_hold", {24'b0, led0},  32'h84);

    // Real baud rate, widest button vector
    btn3[15] = 1'b1;
    tick(7);
    chk("t6_led_8f", {24'b0, led3}, 32'h8F);
    wait_start(3, 20, "t6", nw);
    rec_frame(3, 217, len, bits, fo);
    chk("t6_frame",  {22'b0, bits[9:0]}, 32'h31E);
    chk("t6_len",    len,                32'd2170);
    chk("t6_bit_ns", fo * CLK_NS,        32'd8680);

    // Reset in the middle of a frame
    btn0[5] = 1'b0;
    wait_start(0, 20, "t1", nw);
    tick(10);
    chk("t1_pre_tx", {31'b0, tx0}, 32'd0);
    rst_n = 1'b0;
    tick(1);
    chk("t1_tx",   {31'b0, tx0},   32'd1);
    chk("t1_busy", {31'b0, busy0}, 32'd0);
    chk("t1_led",  {24'b0, led0},  32'd0);
    chk("t1_ovf",  {31'b0, ovf0},  32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
